// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
// Shared definitions for the DDR refresh scheduler: FSM state encoding,
// default timing constants and a busy-state decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ddr_pkg;

   localparam int DEF_T_REFI        = 7800;
   localparam int DEF_T_RFC         = 260;
   localparam int DEF_T_RP          = 14;
   localparam int DEF_ALMOST_MARGIN = 64;
   localparam int DEF_MAX_PEND      = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COUNT    = 3'd1,
      ST_PEND     = 3'd2,
      ST_PREA     = 3'd3,
      ST_WAIT_RP  = 3'd4,
      ST_REF      = 3'd5,
      ST_WAIT_RFC = 3'd6,
      ST_DONE     = 3'd7
   } state_e;

   // The scheduler owns the command bus in every state past COUNT.
   function automatic logic is_busy(input state_e s);
      return (s != ST_IDLE) && (s != ST_COUNT);
   endfunction

endpackage

// File: rtl/ddr_timer.sv
// ---------------------------------------------------------------------------
// ddr_timer
// Loadable down-counter with a zero flag, shared by the tRP and tRFC waits.
// Loading value N-1 makes o_zero rise N cycles after the load cycle.
// Ports:
//   i_clk       clock
//   i_rst       synchronous active-high reset (counter -> 0)
//   i_load      load i_load_val this cycle
//   i_load_val  value to load
//   o_zero      counter is zero
// ---------------------------------------------------------------------------
module ddr_timer #(
   parameter int W = 9
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ddr_refresh_sched.sv
// ---------------------------------------------------------------------------
// ddr_refresh_sched
// DRAM auto-refresh scheduler. A free-running interval timer accrues owed
// refreshes; the FSM takes the command bus, precharges if needed, issues REF
// and waits out tRFC.
//
// Optional feature macro: REFRESH_POSTPONE_EN
//   undefined : service as soon as one refresh is owed (owed count <= 2).
//   defined   : postpone while traffic is active, up to MAX_PEND owed; a
//               forced service at MAX_PEND drains all owed refreshes while
//               holding busy.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   ini_done        DRAM initialization complete
//   rw_idle         no CAS burst in flight
//   act_idle        all banks precharged
//   clear_refresh   discard owed refreshes and restart the interval
//   busy            scheduler owns the command bus
//   refresh_almost  interval expiry within ALMOST_MARGIN clocks
//   prea_rdy        1-cycle pulse: issue PRECHARGE-ALL
//   refresh_rdy     1-cycle pulse: issue REF
//   refresh_done    1-cycle pulse: tRFC elapsed
//   pend_cnt        owed refreshes
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for DRAM init
// COUNT    | interval running, bus released
// PEND     | bus taken, waiting for in-flight bursts to finish
// PREA     | PRECHARGE-ALL issued this cycle
// WAIT_RP  | tRP wait
// REF      | REF issued this cycle
// WAIT_RFC | tRFC wait (never cut short, clear is deferred past it)
// DONE     | tRFC elapsed
// ---------------------------------------------------------------------------
module ddr_refresh_sched
   import ddr_pkg::*;
#(
   parameter int T_REFI        = DEF_T_REFI,
   parameter int T_RFC         = DEF_T_RFC,
   parameter int T_RP          = DEF_T_RP,
   parameter int ALMOST_MARGIN = DEF_ALMOST_MARGIN,
   parameter int MAX_PEND      = DEF_MAX_PEND
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ini_done,
   input  logic       rw_idle,
   input  logic       act_idle,
   input  logic       clear_refresh,
   output logic       busy,
   output logic       refresh_almost,
   output logic       prea_rdy,
   output logic       refresh_rdy,
   output logic       refresh_done,
   output logic [3:0] pend_cnt
);

   localparam int                 TW      = $clog2(T_REFI + 1);
   localparam logic [TW-1:0]      REFI_M1 = TW'(T_REFI - 1);
   localparam int                 TMR_MAX = (T_RFC > T_RP) ? T_RFC : T_RP;
   localparam int                 TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0]   RP_M1   = TMR_W'(T_RP - 1);
   localparam logic [TMR_W-1:0]   RFC_M1  = TMR_W'(T_RFC - 1);
`ifdef REFRESH_POSTPONE_EN
   localparam logic [3:0]         PEND_CAP = 4'(MAX_PEND);
`else
   // Immediate service means at most one more interval can expire before
   // the outstanding REF retires; never exceed MAX_PEND either way.
   localparam logic [3:0]         PEND_CAP = 4'((MAX_PEND < 2) ? MAX_PEND : 2);
`endif

   state_e           r_state;
   state_e           w_next;
   logic [TW-1:0]    r_timer;
   logic [3:0]       r_pend;
   logic             r_clr_pend;
   logic             w_expire;
   logic             w_almost;
   logic             w_service;
   logic             w_defer_zone;
   logic             w_clr_apply;
   logic             w_ref_dec;
   logic             w_tmr_load;
   logic [TMR_W-1:0] w_tmr_val;
   logic             w_tmr_zero;

   assign w_expire = ini_done && (r_timer == '0);
   assign w_almost = ini_done && (32'(r_timer) <= ALMOST_MARGIN);
   assign w_ref_dec = (r_state == ST_REF);

   // REF has already gone out in REF, so a clear there must also wait for
   // the full tRFC; it is applied on the way out of DONE.
   assign w_defer_zone = (r_state == ST_REF) || (r_state == ST_WAIT_RFC);
   assign w_clr_apply  = (clear_refresh && !w_defer_zone) ||
                         ((r_state == ST_DONE) && r_clr_pend);

`ifdef REFRESH_POSTPONE_EN
   logic r_forced;

   assign w_service = ((r_pend != 4'd0) && rw_idle && !w_almost) ||
                      (r_pend == PEND_CAP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_forced <= 1'b0;
      end else if ((w_next == ST_COUNT) || (w_next == ST_IDLE)) begin
         r_forced <= 1'b0;
      end else if ((r_state == ST_COUNT) && (w_next == ST_PEND) &&
                   (r_pend == PEND_CAP)) begin
         r_forced <= 1'b1;
      end
   end
`else
   assign w_service = (r_pend != 4'd0);
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (ini_done) w_next = ST_COUNT;
         ST_COUNT:    if (w_service) w_next = ST_PEND;
         ST_PEND:     if (rw_idle) w_next = act_idle ? ST_REF : ST_PREA;
         ST_PREA:     w_next = ST_WAIT_RP;
         ST_WAIT_RP:  if (w_tmr_zero) w_next = ST_REF;
         ST_REF:      w_next = ST_WAIT_RFC;
         ST_WAIT_RFC: if (w_tmr_zero) w_next = ST_DONE;
         ST_DONE: begin
`ifdef REFRESH_POSTPONE_EN
            w_next = (r_forced && (r_pend != 4'd0)) ? ST_PEND : ST_COUNT;
`else
            w_next = ST_COUNT;
`endif
         end
         default:     w_next = ST_IDLE;
      endcase
      if (w_clr_apply && (r_state != ST_IDLE)) begin
         w_next = ST_COUNT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || w_clr_apply || !ini_done || (r_timer == '0)) begin
         r_timer <= REFI_M1;
      end else begin
         r_timer <= r_timer - 1'b1;
      end
   end

   // Expiry in the same cycle as the REF decrement cancels out.
   always_ff @(posedge clk) begin
      if (rst || w_clr_apply) begin
         r_pend <= 4'd0;
      end else if (w_expire && !w_ref_dec) begin
         if (r_pend < PEND_CAP) r_pend <= r_pend + 4'd1;
      end else if (!w_expire && w_ref_dec) begin
         if (r_pend != 4'd0) r_pend <= r_pend - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (r_state == ST_DONE)) begin
         r_clr_pend <= 1'b0;
      end else if (clear_refresh && w_defer_zone) begin
         r_clr_pend <= 1'b1;
      end
   end

   assign w_tmr_load = (r_state == ST_PREA) || (r_state == ST_REF);
   assign w_tmr_val  = (r_state == ST_PREA) ? RP_M1 : RFC_M1;

   ddr_timer #(.W(TMR_W)) u_tmr (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_zero     (w_tmr_zero)
   );

   assign busy           = is_busy(r_state);
   assign refresh_almost = w_almost;
   assign prea_rdy       = (r_state == ST_PREA);
   assign refresh_rdy    = (r_state == ST_REF);
   assign refresh_done   = (r_state == ST_DONE);
   assign pend_cnt       = r_pend;

endmodule

// File: tb/tb_ddr_refresh_sched.sv
module tb_ddr_refresh_sched;

   localparam int T_REFI = 100;
   localparam int T_RFC  = 10;
   localparam int T_RP   = 3;
   localparam int MARGIN = 5;
   localparam int MAXP   = 8;

   localparam int K_PREA = 1;
   localparam int K_REF  = 2;
   localparam int K_DONE = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       ini_done;
   logic       rw_idle;
   logic       act_idle;
   logic       clear_refresh;
   logic       busy;
   logic       refresh_almost;
   logic       prea_rdy;
   logic       refresh_rdy;
   logic       refresh_done;
   logic [3:0] pend_cnt;

   ddr_refresh_sched #(
      .T_REFI(T_REFI), .T_RFC(T_RFC), .T_RP(T_RP),
      .ALMOST_MARGIN(MARGIN), .MAX_PEND(MAXP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ini_done       (ini_done),
      .rw_idle        (rw_idle),
      .act_idle       (act_idle),
      .clear_refresh  (clear_refresh),
      .busy           (busy),
      .refresh_almost (refresh_almost),
      .prea_rdy       (prea_rdy),
      .refresh_rdy    (refresh_rdy),
      .refresh_done   (refresh_done),
      .pend_cnt       (pend_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int c0 = 0;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   ev_t sb[$];
   bit  sb_en = 1'b0;
   int  m_kind;
   ev_t m_e;

   // Pulse scoreboard: every pulse seen must match the next expected event.
   always @(negedge clk) begin
      if (sb_en && (prea_rdy || refresh_rdy || refresh_done)) begin
         m_kind = prea_rdy ? K_PREA : (refresh_rdy ? K_REF : K_DONE);
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got pulse kind %0d at cycle %0d, none expected", m_kind, cyc - c0);
         end else begin
            m_e = sb.pop_front();
            if ((m_kind !== m_e.kind) || (cyc !== m_e.cyc)) begin
               n_errors++;
               $display("FAIL sb_pulse: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                        m_kind, cyc - c0, m_e.kind, m_e.cyc - c0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int k, input int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic start_run();
      sb_en = 1'b0;
      sb.delete();
      rst = 1'b1;
      ini_done = 1'b0;
      clear_refresh = 1'b0;
      rw_idle = 1'b1;
      act_idle = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      ini_done = 1'b1;
      c0 = cyc;
      sb_en = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ini_done = 1'b1; rw_idle = 1'b1; act_idle = 1'b1; clear_refresh = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({busy, refresh_almost, prea_rdy, refresh_rdy, refresh_done, pend_cnt} !== 9'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b, expected all zero",
                  {busy, refresh_almost, prea_rdy, refresh_rdy, refresh_done, pend_cnt});
      end
      rst = 1'b0;
      ini_done = 1'b0;
      repeat (150) tick();
      n_checks++;
      if ({busy, refresh_almost, pend_cnt} !== 6'd0) begin
         n_errors++;
         $display("FAIL no_init_frozen: busy/almost/pend got %b, expected 0", {busy, refresh_almost, pend_cnt});
      end
   endtask

   task automatic test_basic();
      int first_alm;
      first_alm = -1;
      start_run();
      push_ev(K_REF,  c0 + 102);
      push_ev(K_DONE, c0 + 113);
      while (cyc < c0 + 120) begin
         tick();
         if (refresh_almost && (first_alm < 0)) first_alm = cyc;
         if (cyc == c0 + 100) begin
            n_checks++;
            if ((pend_cnt !== 4'd1) || (busy !== 1'b0) || (refresh_almost !== 1'b0)) begin
               n_errors++;
               $display("FAIL basic_expiry: pend %0d busy %b almost %b, expected 1 0 0",
                        pend_cnt, busy, refresh_almost);
            end
         end
         if (cyc == c0 + 101) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_errors++;
               $display("FAIL basic_busy_pend: got %b expected 1", busy);
            end
         end
      end
      n_checks++;
      if (first_alm !== c0 + 94) begin
         n_errors++;
         $display("FAIL basic_almost_rise: got cycle %0d expected 94", first_alm - c0);
      end
      n_checks++;
      if ((pend_cnt !== 4'd0) || (busy !== 1'b0) || (sb.size() !== 0)) begin
         n_errors++;
         $display("FAIL basic_end: pend %0d busy %b left %0d, expected 0 0 0", pend_cnt, busy, sb.size());
      end
   endtask

   task automatic test_prea();
      int gaps;
      gaps = 0;
      start_run();
      act_idle = 1'b0;
      push_ev(K_PREA, c0 + 102);
      push_ev(K_REF,  c0 + 106);
      push_ev(K_DONE, c0 + 117);
      while (cyc < c0 + 125) begin
         tick();
         if ((cyc >= c0 + 101) && (cyc <= c0 + 117) && (busy !== 1'b1)) gaps++;
      end
      n_checks++;
      if (gaps !== 0) begin
         n_errors++;
         $display("FAIL prea_busy: got %0d idle cycles during service, expected 0", gaps);
      end
      n_checks++;
      if (sb.size() !== 0) begin
         n_errors++;
         $display("FAIL prea_missing: got %0d events unseen, expected 0", sb.size());
      end
   endtask

`ifndef REFRESH_POSTPONE_EN
   task automatic test_rw_hold();
      int gaps;
      gaps = 0;
      start_run();
      rw_idle = 1'b0;
      push_ev(K_REF,  c0 + 131);
      push_ev(K_DONE, c0 + 142);
      while (cyc < c0 + 130) begin
         tick();
         if ((cyc >= c0 + 101) && (busy !== 1'b1)) gaps++;
      end
      rw_idle = 1'b1;
      while (cyc < c0 + 150) tick();
      n_checks++;
      if (gaps !== 0) begin
         n_errors++;
         $display("FAIL rwhold_busy: got %0d idle cycles while held, expected 0", gaps);
      end
      n_checks++;
      if ((sb.size() !== 0) || (pend_cnt !== 4'd0)) begin
         n_errors++;
         $display("FAIL rwhold_end: left %0d pend %0d, expected 0 0", sb.size(), pend_cnt);
      end
   endtask

   task automatic test_clear_pend();
      start_run();
      rw_idle = 1'b0;
      while (cyc < c0 + 305) tick();
      n_checks++;
      if ((pend_cnt !== 4'd2) || (busy !== 1'b1)) begin
         n_errors++;
         $display("FAIL clear_before: pend %0d busy %b, expected 2 1", pend_cnt, busy);
      end
      clear_refresh = 1'b1;
      tick();
      clear_refresh = 1'b0;
      n_checks++;
      if ((pend_cnt !== 4'd0) || (busy !== 1'b0)) begin
         n_errors++;
         $display("FAIL clear_after: pend %0d busy %b, expected 0 0", pend_cnt, busy);
      end
      while (cyc < c0 + 405) tick();
      n_checks++;
      if (pend_cnt !== 4'd0) begin
         n_errors++;
         $display("FAIL clear_reload_early: pend %0d expected 0", pend_cnt);
      end
      tick();
      n_checks++;
      if (pend_cnt !== 4'd1) begin
         n_errors++;
         $display("FAIL clear_reload_expiry: pend %0d expected 1", pend_cnt);
      end
   endtask
`endif

   task automatic test_clear_defer();
      start_run();
      push_ev(K_REF,  c0 + 102);
      push_ev(K_DONE, c0 + 113);
      push_ev(K_REF,  c0 + 216);
      push_ev(K_DONE, c0 + 227);
      while (cyc < c0 + 105) tick();
      clear_refresh = 1'b1;
      tick();
      clear_refresh = 1'b0;
      while (cyc < c0 + 213) tick();
      n_checks++;
      if (pend_cnt !== 4'd0) begin
         n_errors++;
         $display("FAIL defer_reload_early: pend %0d expected 0", pend_cnt);
      end
      tick();
      n_checks++;
      if (pend_cnt !== 4'd1) begin
         n_errors++;
         $display("FAIL defer_reload_expiry: pend %0d expected 1", pend_cnt);
      end
      while (cyc < c0 + 235) tick();
      n_checks++;
      if ((sb.size() !== 0) || (pend_cnt !== 4'd0)) begin
         n_errors++;
         $display("FAIL defer_end: left %0d pend %0d, expected 0 0", sb.size(), pend_cnt);
      end
   endtask

   task automatic test_rst_rfc();
      start_run();
      push_ev(K_REF, c0 + 102);
      while (cyc < c0 + 105) tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({busy, refresh_almost, prea_rdy, refresh_rdy, refresh_done, pend_cnt} !== 9'd0) begin
         n_errors++;
         $display("FAIL rst_rfc_outputs: got %b, expected all zero",
                  {busy, refresh_almost, prea_rdy, refresh_rdy, refresh_done, pend_cnt});
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if ({busy, prea_rdy, refresh_rdy, refresh_done, pend_cnt} !== 8'd0) begin
         n_errors++;
         $display("FAIL rst_rfc_after: got %b, expected all zero",
                  {busy, prea_rdy, refresh_rdy, refresh_done, pend_cnt});
      end
      while (cyc < c0 + 125) tick();
      n_checks++;
      if (sb.size() !== 0) begin
         n_errors++;
         $display("FAIL rst_rfc_missing: got %0d events unseen, expected 0", sb.size());
      end
   endtask

`ifdef REFRESH_POSTPONE_EN
   task automatic test_postpone();
      int pulses;
      bit seen;
      pulses = 0;
      seen = 1'b0;
      start_run();
      sb_en = 1'b0;
      rw_idle = 1'b0;
      while ((pend_cnt !== 4'd8) && (cyc < c0 + 900)) tick();
      n_checks++;
      if ((pend_cnt !== 4'd8) || (cyc !== c0 + 800)) begin
         n_errors++;
         $display("FAIL postpone_fill: pend %0d at cycle %0d, expected 8 at 800", pend_cnt, cyc - c0);
      end
      rw_idle = 1'b1;
      while (cyc < c0 + 1300) begin
         tick();
         if (refresh_rdy) pulses++;
         if (busy) seen = 1'b1;
         else if (seen) break;
      end
      n_checks++;
      if ((pulses < 8) || (pend_cnt !== 4'd0) || !seen) begin
         n_errors++;
         $display("FAIL postpone_drain: pulses %0d pend %0d, expected >=8 and 0", pulses, pend_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_prea();
`ifndef REFRESH_POSTPONE_EN
      test_rw_hold();
      test_clear_pend();
`else
      test_postpone();
`endif
      test_clear_defer();
      test_rst_rfc();
      sb_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
